// File: rtl/fuel_pump_unlock.sv
// Hidden-switch fuel-pump immobiliser: synchronised, debounced inputs drive an unlock FSM.
// Raw inputs reach the FSM 2 + DEBOUNCE_CYCLES cycles after a clean step; outputs are decoded from registers.
module fuel_pump_unlock #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned PRESS_COUNT     = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 64,
  parameter int unsigned MAX_FAILS       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       hidden_sw_raw,
  input  logic       brake_raw,
  output logic       switch,
  output logic       brake,
  output logic       lockout,
  output logic [1:0] fail_count
);

  typedef enum logic [1:0] {ST_LOCKED, ST_COUNTING, ST_UNLOCKED, ST_LOCKOUT} state_t;

  localparam logic [3:0]  DB_LAST      = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  TIMER_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  PRESS_TARGET = 3'(PRESS_COUNT);
  localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]  FAIL_LIMIT   = 2'(MAX_FAILS);

  // Bit 0 carries the hidden switch, bit 1 the brake pedal.
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [1:0][3:0] db_cnt_q, db_cnt_d;
  logic            hidden_prev_q, hidden_prev_d;
  state_t          state_q, state_d;
  logic [2:0]      press_cnt_q, press_cnt_d;
  logic [7:0]      timer_q, timer_d;
  logic [15:0]     lo_timer_q, lo_timer_d;
  logic [1:0]      fail_q, fail_d;

  logic       press, brake_db, fail_attempt;
  logic [2:0] press_inc;
  logic [7:0] timer_inc;
  logic [1:0] fail_inc;

  always_comb begin
    sync1_d       = {brake_raw, hidden_sw_raw};
    sync2_d       = sync1_q;
    db_d          = db_q;
    db_cnt_d      = '0;
    hidden_prev_d = db_q[0];
    // The count only runs while the synchronised level disagrees with the debounced one.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign press     = db_q[0] & ~hidden_prev_q;
  assign brake_db  = db_q[1];
  assign press_inc = (press_cnt_q == 3'd7) ? press_cnt_q : press_cnt_q + 3'd1;
  assign timer_inc = (timer_q == TIMER_LAST) ? timer_q : timer_q + 8'd1;
  assign fail_inc  = (fail_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    press_cnt_d  = press_cnt_q;
    timer_d      = timer_q;
    lo_timer_d   = lo_timer_q;
    fail_d       = fail_q;
    fail_attempt = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (press && ignition && brake_db) begin
          press_cnt_d = 3'd1;
          timer_d     = '0;
          if (PRESS_TARGET == 3'd1) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
          end else begin
            state_d = ST_COUNTING;
          end
        end
      end
      ST_COUNTING: begin
        // Losing brake or ignition outranks a press landing in the same cycle.
        if (!ignition || !brake_db) begin
          fail_attempt = 1'b1;
        end else if (press) begin
          press_cnt_d = press_inc;
          timer_d     = '0;
          if (press_inc == PRESS_TARGET) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMER_LAST) fail_attempt = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (!ignition) state_d = ST_LOCKED;
      end
      ST_LOCKOUT: begin
        if (lo_timer_q >= LOCKOUT_LAST) begin
          state_d    = ST_LOCKED;
          fail_d     = '0;
          lo_timer_d = '0;
        end else begin
          lo_timer_d = lo_timer_q + 16'd1;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
    if (fail_attempt) begin
      fail_d = fail_inc;
      if (fail_inc == FAIL_LIMIT) begin
        state_d    = ST_LOCKOUT;
        lo_timer_d = '0;
      end else begin
        state_d = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_q          <= '0;
      db_cnt_q      <= '0;
      hidden_prev_q <= 1'b0;
      state_q       <= ST_LOCKED;
      press_cnt_q   <= '0;
      timer_q       <= '0;
      lo_timer_q    <= '0;
      fail_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_cnt_q      <= db_cnt_d;
      hidden_prev_q <= hidden_prev_d;
      state_q       <= state_d;
      press_cnt_q   <= press_cnt_d;
      timer_q       <= timer_d;
      lo_timer_q    <= lo_timer_d;
      fail_q        <= fail_d;
    end
  end

  assign switch     = (state_q == ST_UNLOCKED);
  assign lockout    = (state_q == ST_LOCKOUT);
  assign brake      = db_q[1];
  assign fail_count = fail_q;

endmodule

// File: tb/tb_fuel_pump_unlock.sv
// Bench for fuel_pump_unlock: hand-derived vector table, corner sequences and random stimulus vs a reference model.
module tb_fuel_pump_unlock;
  localparam int DB = 4, TO = 16, PC = 3, LO = 64, MF = 3;
  localparam int M_LOCKED = 0, M_COUNT = 1, M_UNLOCK = 2, M_LOCKOUT = 3;

  logic       clock = 1'b0;
  logic       reset, ignition, hidden_sw_raw, brake_raw;
  logic       switch, brake, lockout;
  logic [1:0] fail_count;

  fuel_pump_unlock #(
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .PRESS_COUNT(PC),
    .LOCKOUT_CYCLES(LO), .MAX_FAILS(MF)
  ) dut (
    .clock(clock), .reset(reset), .ignition(ignition),
    .hidden_sw_raw(hidden_sw_raw), .brake_raw(brake_raw),
    .switch(switch), .brake(brake), .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  wire [4:0] dut_o = {switch, lockout, brake, fail_count};

  int passed = 0, total = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {sw,lo,brk,fails}=%b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: raw-sample history windows for debouncing, counters with plain arithmetic.
  int       m_mode, m_presses, m_since, m_left, m_fails;
  bit       m_db_h, m_db_b, m_prev_h;
  bit [DB:0] hh, hb;

  task automatic model_reset();
    m_mode = M_LOCKED; m_presses = 0; m_since = 0; m_left = 0; m_fails = 0;
    m_db_h = 0; m_db_b = 0; m_prev_h = 0; hh = '0; hb = '0;
  endtask

  task automatic model_step();
    bit press, fail;
    press = m_db_h && !m_prev_h;
    fail  = 0;
    case (m_mode)
      M_LOCKED: if (press && ignition && m_db_b) begin
        m_presses = 1; m_since = 0;
        if (PC == 1) begin m_mode = M_UNLOCK; m_fails = 0; end
        else m_mode = M_COUNT;
      end
      M_COUNT: begin
        if (!ignition || !m_db_b) fail = 1;
        else if (press) begin
          m_presses++; m_since = 0;
          if (m_presses == PC) begin m_mode = M_UNLOCK; m_fails = 0; end
        end else begin
          m_since++;
          if (m_since == TO - 1) fail = 1;
        end
      end
      M_UNLOCK: if (!ignition) m_mode = M_LOCKED;
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_LOCKED; m_fails = 0; end
      end
    endcase
    if (fail) begin
      m_fails++;
      if (m_fails == MF) begin m_mode = M_LOCKOUT; m_left = LO; end
      else m_mode = M_LOCKED;
    end
    m_prev_h = m_db_h;
    // hh[k] holds the raw level seen k+1 edges ago; the debouncer at this edge sees hh[DB:1].
    if (hh[DB:1] == {DB{1'b1}}) m_db_h = 1; else if (hh[DB:1] == '0) m_db_h = 0;
    if (hb[DB:1] == {DB{1'b1}}) m_db_b = 1; else if (hb[DB:1] == '0) m_db_b = 0;
    hh = {hh[DB-1:0], hidden_sw_raw};
    hb = {hb[DB-1:0], brake_raw};
  endtask

  function automatic logic [4:0] model_o();
    return {m_mode == M_UNLOCK, m_mode == M_LOCKOUT, m_db_b, 2'(m_fails)};
  endfunction

  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset(); else model_step();
    #1;
    check("model", dut_o, model_o());
  endtask

  task automatic run(input bit ign, input bit hid, input bit brk, input int n);
    ignition = ign; hidden_sw_raw = hid; brake_raw = brk;
    repeat (n) cycle();
  endtask

  typedef struct {
    bit       ign, hid, brk;
    int       n;
    bit       sw, lo, br;
    bit [1:0] fl;
  } vec_t;
  vec_t tbl[$];

  initial begin
    reset = 1; ignition = 0; hidden_sw_raw = 0; brake_raw = 0;
    model_reset();
    cycle(); cycle();
    check("reset_state", dut_o, 5'b00000);
    reset = 0;

    // Three clean presses ten cycles apart, then ignition drop and re-raise.
    tbl.push_back('{1, 0, 1, 10, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 1,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 1,  1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 1,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 5,  0, 0, 1, 0});
    // Three timeouts: each fails exactly 16 cycles after its press event, the third locks out.
    for (int r = 0; r < 3; r++) begin
      tbl.push_back('{1, 1, 1, 5,  0, 0, 1, 2'(r)});
      tbl.push_back('{1, 0, 1, 1,  0, 0, 1, 2'(r)});
      tbl.push_back('{1, 0, 1, 15, 0, 0, 1, 2'(r)});
      tbl.push_back('{1, 0, 1, 1,  0, r == 2, 1, 2'(r + 1)});
    end
    // Lockout lasts 64 cycles and ignores a press.
    tbl.push_back('{1, 1, 1, 5,  0, 1, 1, 3});
    tbl.push_back('{1, 0, 1, 58, 0, 1, 1, 3});
    tbl.push_back('{1, 0, 1, 1,  0, 0, 1, 0});
    // A press with ignition off is ignored, not a fail.
    tbl.push_back('{0, 1, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 5,  0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 20, 0, 0, 1, 0});

    foreach (tbl[i]) begin
      run(tbl[i].ign, tbl[i].hid, tbl[i].brk, tbl[i].n);
      check($sformatf("vec%0d", i), dut_o, {tbl[i].sw, tbl[i].lo, tbl[i].br, tbl[i].fl});
    end

    // Glitches of 1, 2 and 3 cycles, then one real press that then times out.
    for (int g = 1; g <= 3; g++) begin
      run(1, 1, 1, g);
      run(1, 0, 1, 6);
    end
    run(1, 1, 1, 20);
    check("bounce_press_pending", dut_o, 5'b00100);
    run(1, 0, 1, 20);
    check("bounce_one_press", dut_o, 5'b00101);

    // Asynchronous reset in the middle of COUNTING.
    run(1, 1, 1, 5);
    run(1, 0, 1, 2);
    #1 reset = 1;
    model_reset();
    #1 check("reset_mid_counting", dut_o, 5'b00000);
    cycle(); cycle();
    reset = 0;
    run(1, 0, 1, 10);
    run(1, 1, 1, 5); run(1, 0, 1, 5);
    run(1, 1, 1, 5); run(1, 0, 1, 5);
    check("two_presses_after_reset", dut_o, 5'b00100);
    run(1, 1, 1, 5); run(1, 0, 1, 2);
    check("unlock_after_reset", dut_o, 5'b10100);

    // Asynchronous reset while UNLOCKED.
    #1 reset = 1;
    model_reset();
    #1 check("reset_mid_unlocked", dut_o, 5'b00000);
    cycle();
    reset = 0;
    run(1, 0, 1, 10);
    check("locked_after_reset", dut_o, 5'b00100);

    // Random stimulus against the model, with occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        model_reset();
        #1 check("rand_reset", dut_o, 5'b00000);
        cycle();
        reset = 0;
      end
      ignition      = ($urandom_range(0, 9) != 0);
      brake_raw     = ($urandom_range(0, 7) != 0);
      hidden_sw_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fuel_pump_unlock.md
FUEL_PUMP_UNLOCK -- requirements
Module: fuel_pump_unlock

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a debounced input changes (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum cycles allowed between hidden-switch presses (range 2..255).
REQ-003 Parameter PRESS_COUNT, default 3, hidden-switch presses required to unlock (range 1..7).
REQ-004 Parameter LOCKOUT_CYCLES, default 64, lockout duration after MAX_FAILS failed attempts (range 1..65535).
REQ-005 Parameter MAX_FAILS, default 3, failed attempts that trigger lockout (range 1..3).
REQ-006 clock  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 ignition  input  1  ignition key on; already synchronous; not debounced.
REQ-009 hidden_sw_raw  input  1  raw hidden switch, asynchronous, bouncing.
REQ-010 brake_raw  input  1  raw brake pedal switch, asynchronous, bouncing.
REQ-011 switch  output  1  fuel-pump enable token; high only in UNLOCKED.
REQ-012 brake  output  1  debounced brake level, forwarded to the fuel pump.
REQ-013 lockout  output  1  high only in LOCKOUT.
REQ-014 fail_count  output  2  failed attempts since last unlock, lockout expiry or reset.

Function
REQ-015 Each raw input SHALL pass a 2-flop synchronizer, then a debouncer whose output takes the synchronized value only after DEBOUNCE_CYCLES consecutive equal samples; any mismatch restarts the count.
REQ-016 Raw-to-debounced latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step; pulses shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never appear.
REQ-017 A press event SHALL be a single cycle in which debounced hidden switch is 1 and its previous-cycle value was 0.
REQ-018 FSM states: LOCKED, COUNTING, UNLOCKED, LOCKOUT; switch and lockout SHALL be decoded directly from the state register.
REQ-019 LOCKED: press event with ignition=1 and brake=1 -> COUNTING, press counter=1, timer=0; if PRESS_COUNT=1 -> UNLOCKED directly.
REQ-020 COUNTING: each press event increments the press counter and clears the timer; otherwise timer increments by 1 per cycle.
REQ-021 COUNTING: press event bringing counter to PRESS_COUNT -> UNLOCKED; fail_count cleared to 0.
REQ-022 COUNTING: timer reaching TIMEOUT_CYCLES-1 with no press that cycle -> failed attempt.
REQ-023 COUNTING: brake=0 or ignition=0 -> failed attempt; this takes priority over a same-cycle press event.
REQ-024 Failed attempt: fail_count+1; if new value equals MAX_FAILS -> LOCKOUT with lockout timer=0, else -> LOCKED.
REQ-025 UNLOCKED: remain while ignition=1 (brake and hidden switch ignored); ignition=0 -> LOCKED next cycle.
REQ-026 LOCKOUT: all inputs ignored; after LOCKOUT_CYCLES cycles -> LOCKED with fail_count=0.
REQ-027 Press counter, timer and lockout timer SHALL saturate, never wrap; fail_count SHALL never exceed MAX_FAILS.
REQ-028 ignition=0 in LOCKED SHALL hold LOCKED; presses without brake or ignition SHALL be ignored, not counted as fails.

Reset
REQ-029 reset=1 SHALL immediately force LOCKED, switch=0, lockout=0, fail_count=0, brake=0, all counters, synchronizers and debouncers to 0, regardless of current state.
REQ-030 After reset deassertion, raw inputs already high SHALL reach debounced outputs after 2 + DEBOUNCE_CYCLES cycles; a hidden switch high at reset release SHALL produce a press event once debounced.

Verification
REQ-031 Defaults, ignition=1, brake held, 3 clean presses spaced 10 cycles -> switch=1 on the cycle after the 3rd debounced rising edge; fail_count=0.
REQ-032 Unlocked, ignition drops to 0 -> switch=0 on the next cycle; re-raise ignition -> switch remains 0.
REQ-033 One press then no further press -> return to LOCKED 16 cycles after the press event; fail_count=1.
REQ-034 Three consecutive failed attempts -> lockout=1 and fail_count=3; presses ignored for 64 cycles; then LOCKED, lockout=0, fail_count=0.
REQ-035 hidden_sw_raw bounce: 1-, 2- and 3-cycle glitches, then a 20-cycle press -> exactly one press event counted.
REQ-036 reset asserted mid-COUNTING and mid-UNLOCKED -> all outputs 0 before the next clock edge; prior presses forgotten.
